// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//    Bundles every bus signal of mem_port_arbiter: the instruction-fetch
//    requester port, the data (MEM-stage) requester port, the shared
//    single-port memory req/ack port and the pipeline stall output.
//    Signal names keep their _i/_o suffixes as seen from the arbiter.
//
// Modports:
//    slave  : the arbiter itself (consumes requests, drives memory/stall).
//    master : the environment (fetch unit, MEM stage and memory model).
//
// Signal summary (direction as seen by the arbiter):
//    if_req_i, if_addr_i                in  fetch request / address
//    if_rdata_o, if_done_o              out fetched word / done pulse
//    d_req_i, d_addr_i, d_wdata_i       in  data request / address / store data
//    d_ctrl_i, d_we_i                   in  size-sign code / write enable
//    d_rdata_o, d_done_o                out load result / done pulse
//    mem_req_o, mem_addr_o, mem_wdata_o out memory request and latched command
//    mem_ctrl_o, mem_we_o               out latched control / write enable
//    mem_ack_i, mem_rdata_i             in  memory completion / read data
//    stall_o                            out pipeline stall
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int size = 32
);
   // fetch port
   logic            if_req_i;
   logic [size-1:0] if_addr_i;
   logic [size-1:0] if_rdata_o;
   logic            if_done_o;

   // data port
   logic            d_req_i;
   logic [size-1:0] d_addr_i;
   logic [size-1:0] d_wdata_i;
   logic [2:0]      d_ctrl_i;
   logic            d_we_i;
   logic [size-1:0] d_rdata_o;
   logic            d_done_o;

   // memory port
   logic            mem_req_o;
   logic [size-1:0] mem_addr_o;
   logic [size-1:0] mem_wdata_o;
   logic [2:0]      mem_ctrl_o;
   logic            mem_we_o;
   logic            mem_ack_i;
   logic [size-1:0] mem_rdata_i;

   // pipeline
   logic            stall_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_rdata_o, if_done_o,
      input  d_req_i, d_addr_i, d_wdata_i, d_ctrl_i, d_we_i,
      output d_rdata_o, d_done_o,
      output mem_req_o, mem_addr_o, mem_wdata_o, mem_ctrl_o, mem_we_o,
      input  mem_ack_i, mem_rdata_i,
      output stall_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_rdata_o, if_done_o,
      output d_req_i, d_addr_i, d_wdata_i, d_ctrl_i, d_we_i,
      input  d_rdata_o, d_done_o,
      input  mem_req_o, mem_addr_o, mem_wdata_o, mem_ctrl_o, mem_we_o,
      output mem_ack_i, mem_rdata_i,
      input  stall_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//    Shares one single-port memory between the instruction-fetch port and the
//    data port of a pipeline. One request per requester is accepted in IDLE,
//    the winner's command is latched onto the memory req/ack interface, and
//    the read data plus a one-cycle done pulse are returned to the winner.
//    Data wins ties, except that after STARVE_LIMIT consecutive data grants
//    with fetch waiting, the next grant goes to fetch.
//
// Ports:
//    clk    in  single clock, rising edge
//    reset  in  synchronous, active-low reset
//    bus    slave modport of mem_port_arbiter_if (fetch, data, memory, stall)
//
// Parameters:
//    size          address/data width (must match the interface instance)
//    STARVE_LIMIT  max consecutive data grants while fetch is pending (>= 1)
//
// Transaction timing (request seen in IDLE at cycle 0):
//    cycle 1   : mem_req_o = 1 (BUSY)
//    cycle k   : mem_ack_i = 1, k >= 1
//    cycle k+1 : done pulse (RESP), mem_req_o = 0
//    cycle k+2 : IDLE, next request may be granted
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int size         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [2:0] CTRL_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Owner encoding recorded at grant time.
   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D  = 1'b1;

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   state_t            state_q;
   logic              owner_q;
   logic [CNT_W-1:0]  starve_cnt_q;
   logic [CNT_W-1:0]  starve_cnt_d;

   logic              mem_req_q;
   logic [size-1:0]   mem_addr_q;
   logic [size-1:0]   mem_wdata_q;
   logic [2:0]        mem_ctrl_q;
   logic              mem_we_q;

   logic [size-1:0]   if_rdata_q;
   logic [size-1:0]   d_rdata_q;
   logic              if_done_q;
   logic              d_done_q;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   logic any_req;
   logic pick_data;

   always_comb begin
      any_req   = bus.if_req_i | bus.d_req_i;
      // Data wins unless fetch is waiting and data has used up its budget.
      pick_data = bus.d_req_i & (~bus.if_req_i | (starve_cnt_q < LIMIT));
   end

   // Starvation counter only moves in IDLE, where grants happen. Any IDLE
   // cycle without a fetch request clears it, so it measures consecutive
   // data grants made while fetch was actually waiting.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (state_q == IDLE) begin
         if (!bus.if_req_i) begin
            starve_cnt_d = '0;
         end else if (pick_data) begin
            if (starve_cnt_q != LIMIT) begin
               starve_cnt_d = starve_cnt_q + 1'b1;
            end
         end else begin
            // fetch is being granted
            starve_cnt_d = '0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= OWNER_IF;
         starve_cnt_q <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_ctrl_q   <= 3'b000;
         mem_we_q     <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         // Done pulses last exactly one cycle unless re-set below.
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
         starve_cnt_q <= starve_cnt_d;

         case (state_q)
            IDLE: begin
               if (any_req) begin
                  mem_req_q <= 1'b1;
                  if (pick_data) begin
                     owner_q     <= OWNER_D;
                     mem_addr_q  <= bus.d_addr_i;
                     mem_wdata_q <= bus.d_wdata_i;
                     mem_ctrl_q  <= bus.d_ctrl_i;
                     mem_we_q    <= bus.d_we_i;
                     state_q     <= BUSY_D;
                  end else begin
                     // Fetch is always a plain word read.
                     owner_q     <= OWNER_IF;
                     mem_addr_q  <= bus.if_addr_i;
                     mem_wdata_q <= '0;
                     mem_ctrl_q  <= CTRL_WORD;
                     mem_we_q    <= 1'b0;
                     state_q     <= BUSY_IF;
                  end
               end
            end

            BUSY_IF, BUSY_D: begin
               // Command registers hold their latched values; wait for ack
               // with no timeout.
               if (bus.mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= RESP;
                  if (owner_q == OWNER_IF) begin
                     if_rdata_q <= bus.mem_rdata_i;
                     if_done_q  <= 1'b1;
                  end else begin
                     // Stores leave the last load result untouched.
                     if (!mem_we_q) begin
                        d_rdata_q <= bus.mem_rdata_i;
                     end
                     d_done_q <= 1'b1;
                  end
               end
            end

            RESP: begin
               // No grant here: the requester may still be dropping the
               // request it just completed.
               state_q <= IDLE;
            end

            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output drive
   // -------------------------------------------------------------------------
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.mem_ctrl_o  = mem_ctrl_q;
   assign bus.mem_we_o    = mem_we_q;

   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_done_o   = if_done_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.d_done_o    = d_done_q;

   // Stall releases combinationally in the done cycle so the pipeline can
   // advance on the same edge that ends the pulse.
   assign bus.stall_o = (bus.if_req_i & ~if_done_q) | (bus.d_req_i & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs are driven on the falling edge
// and outputs are checked 1 time unit later, so registered outputs show the
// result of the previous rising edge and stall_o reflects the current inputs.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic reset;

   int tests_run = 0;
   int tests_failed = 0;

   mem_port_arbiter_if #(.size(32)) bus ();

   mem_port_arbiter #(
      .size         (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      // inputs
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [2:0]  d_ctrl;
      logic        d_we;
      logic        ack;
      logic [31:0] rdata;
      // expected outputs
      logic        e_mem_req;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [2:0]  e_ctrl;
      logic        e_we;
      logic        e_if_done;
      logic        e_d_done;
      logic        e_stall;
      logic [31:0] e_if_rdata;
      logic [31:0] e_d_rdata;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic drive_idle();
      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = 32'h0;
      bus.d_req_i     = 1'b0;
      bus.d_addr_i    = 32'h0;
      bus.d_wdata_i   = 32'h0;
      bus.d_ctrl_i    = 3'b000;
      bus.d_we_i      = 1'b0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'h0;
   endtask

   initial begin
      // Single fetch, spurious ack, store with 3 wait cycles, then a load.
      //            if  if_addr       d  d_addr        d_wdata       ctl   we ack rdata          | req addr          wdata         ctl   we ifd dd st if_rdata      d_rdata
      vecs[0]  = '{1, 32'h100,      0, 32'h0,      32'h0,      3'd0, 0, 0, 32'h0,        0, 32'h0,      32'h0,      3'd0, 0, 0, 0, 1, 32'h0,        32'h0};
      vecs[1]  = '{1, 32'h100,      0, 32'h0,      32'h0,      3'd0, 0, 1, 32'hDEADBEEF, 1, 32'h100,    32'h0,      3'd2, 0, 0, 0, 1, 32'h0,        32'h0};
      vecs[2]  = '{1, 32'h100,      0, 32'h0,      32'h0,      3'd0, 0, 0, 32'h0,        0, 32'h100,    32'h0,      3'd2, 0, 1, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[3]  = '{0, 32'h0,        0, 32'h0,      32'h0,      3'd0, 0, 0, 32'h0,        0, 32'h100,    32'h0,      3'd2, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[4]  = '{0, 32'h0,        0, 32'h0,      32'h0,      3'd0, 0, 1, 32'h11111111, 0, 32'h100,    32'h0,      3'd2, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[5]  = '{0, 32'h0,        0, 32'h0,      32'h0,      3'd0, 0, 0, 32'h0,        0, 32'h100,    32'h0,      3'd2, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[6]  = '{0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 32'h0,        0, 32'h100,    32'h0,      3'd2, 0, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[7]  = '{0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[8]  = '{0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[9]  = '{0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[10] = '{0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 1, 32'h12345678, 1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[11] = '{0, 32'h0,        1, 32'h2004,   32'h55AA,   3'd1, 1, 0, 32'h0,        0, 32'h2004,   32'h55AA,   3'd1, 1, 0, 1, 0, 32'hDEADBEEF, 32'h0};
      vecs[12] = '{0, 32'h0,        0, 32'h0,      32'h0,      3'd0, 0, 0, 32'h0,        0, 32'h2004,   32'h55AA,   3'd1, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[13] = '{0, 32'h0,        1, 32'h3000,   32'hFFFF,   3'd4, 0, 0, 32'h0,        0, 32'h2004,   32'h55AA,   3'd1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[14] = '{0, 32'h0,        1, 32'h3000,   32'hFFFF,   3'd4, 0, 1, 32'hCAFEF00D, 1, 32'h3000,   32'hFFFF,   3'd4, 0, 0, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[15] = '{0, 32'h0,        1, 32'h3000,   32'hFFFF,   3'd4, 0, 0, 32'h0,        0, 32'h3000,   32'hFFFF,   3'd4, 0, 0, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D};
      vecs[16] = '{0, 32'h0,        0, 32'h0,      32'h0,      3'd0, 0, 0, 32'h0,        0, 32'h3000,   32'hFFFF,   3'd4, 0, 0, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D};

      // ---------------------------------------------------------------
      // Reset state
      // ---------------------------------------------------------------
      drive_idle();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_mem_req",   32'(bus.mem_req_o),  32'h0);
      chk("reset_mem_we",    32'(bus.mem_we_o),   32'h0);
      chk("reset_if_done",   32'(bus.if_done_o),  32'h0);
      chk("reset_d_done",    32'(bus.d_done_o),   32'h0);
      chk("reset_mem_addr",  bus.mem_addr_o,      32'h0);
      chk("reset_mem_wdata", bus.mem_wdata_o,     32'h0);
      chk("reset_mem_ctrl",  32'(bus.mem_ctrl_o), 32'h0);
      chk("reset_if_rdata",  bus.if_rdata_o,      32'h0);
      chk("reset_d_rdata",   bus.d_rdata_o,       32'h0);
      chk("reset_stall",     32'(bus.stall_o),    32'h0);
      $display("[TB] reset state checked");

      // ---------------------------------------------------------------
      // Table-driven vectors
      // ---------------------------------------------------------------
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         bus.if_req_i    = vecs[i].if_req;
         bus.if_addr_i   = vecs[i].if_addr;
         bus.d_req_i     = vecs[i].d_req;
         bus.d_addr_i    = vecs[i].d_addr;
         bus.d_wdata_i   = vecs[i].d_wdata;
         bus.d_ctrl_i    = vecs[i].d_ctrl;
         bus.d_we_i      = vecs[i].d_we;
         bus.mem_ack_i   = vecs[i].ack;
         bus.mem_rdata_i = vecs[i].rdata;
         #1;
         chk($sformatf("v%0d_mem_req", i),  32'(bus.mem_req_o),  32'(vecs[i].e_mem_req));
         chk($sformatf("v%0d_mem_addr", i), bus.mem_addr_o,      vecs[i].e_addr);
         chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o,    vecs[i].e_wdata);
         chk($sformatf("v%0d_mem_ctrl", i), 32'(bus.mem_ctrl_o), 32'(vecs[i].e_ctrl));
         chk($sformatf("v%0d_mem_we", i),   32'(bus.mem_we_o),   32'(vecs[i].e_we));
         chk($sformatf("v%0d_if_done", i),  32'(bus.if_done_o),  32'(vecs[i].e_if_done));
         chk($sformatf("v%0d_d_done", i),   32'(bus.d_done_o),   32'(vecs[i].e_d_done));
         chk($sformatf("v%0d_stall", i),    32'(bus.stall_o),    32'(vecs[i].e_stall));
         chk($sformatf("v%0d_if_rdata", i), bus.if_rdata_o,      vecs[i].e_if_rdata);
         chk($sformatf("v%0d_d_rdata", i),  bus.d_rdata_o,       vecs[i].e_d_rdata);
         $display("[TB] vector %0d: if_req=%0b d_req=%0b ack=%0b -> mem_req=%0b addr=0x%08h done=%0b/%0b stall=%0b",
                  i, vecs[i].if_req, vecs[i].d_req, vecs[i].ack, bus.mem_req_o,
                  bus.mem_addr_o, bus.if_done_o, bus.d_done_o, bus.stall_o);
      end

      // ---------------------------------------------------------------
      // Simultaneous requests: data first, fetch after data drops
      // ---------------------------------------------------------------
      @(negedge clk);
      drive_idle();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h400;
      bus.d_req_i  = 1'b1; bus.d_addr_i  = 32'h800; bus.d_ctrl_i = 3'b010;
      #1;
      chk("sim_c0_stall",   32'(bus.stall_o),   32'h1);
      chk("sim_c0_mem_req", 32'(bus.mem_req_o), 32'h0);
      @(negedge clk);
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hA0A0A0A0;
      #1;
      chk("sim_c1_mem_req", 32'(bus.mem_req_o), 32'h1);
      chk("sim_c1_addr",    bus.mem_addr_o,     32'h800);
      chk("sim_c1_stall",   32'(bus.stall_o),   32'h1);
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      chk("sim_c2_d_done",  32'(bus.d_done_o),  32'h1);
      chk("sim_c2_if_done", 32'(bus.if_done_o), 32'h0);
      chk("sim_c2_stall",   32'(bus.stall_o),   32'h1);
      chk("sim_c2_d_rdata", bus.d_rdata_o,      32'hA0A0A0A0);
      $display("[TB] simultaneous: data transaction done, d_rdata=0x%08h", bus.d_rdata_o);
      @(negedge clk);
      bus.d_req_i = 1'b0;
      #1;
      chk("sim_c3_mem_req", 32'(bus.mem_req_o), 32'h0);
      chk("sim_c3_stall",   32'(bus.stall_o),   32'h1);
      @(negedge clk);
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hB0B0B0B0;
      #1;
      chk("sim_c4_mem_req", 32'(bus.mem_req_o), 32'h1);
      chk("sim_c4_addr",    bus.mem_addr_o,     32'h400);
      chk("sim_c4_ctrl",    32'(bus.mem_ctrl_o), 32'h2);
      chk("sim_c4_stall",   32'(bus.stall_o),   32'h1);
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      chk("sim_c5_if_done", 32'(bus.if_done_o), 32'h1);
      chk("sim_c5_stall",   32'(bus.stall_o),   32'h0);
      chk("sim_c5_if_rdata", bus.if_rdata_o,    32'hB0B0B0B0);
      $display("[TB] simultaneous: fetch transaction done, if_rdata=0x%08h", bus.if_rdata_o);
      @(negedge clk);
      bus.if_req_i = 1'b0;
      #1;
      chk("sim_c6_if_done", 32'(bus.if_done_o), 32'h0);
      chk("sim_c6_stall",   32'(bus.stall_o),   32'h0);

      // ---------------------------------------------------------------
      // Starvation: both held back-to-back -> D D D D F D D D D F
      // ---------------------------------------------------------------
      @(negedge clk);
      drive_idle();
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h400;
      bus.d_req_i  = 1'b1; bus.d_addr_i  = 32'h800; bus.d_ctrl_i = 3'b010;
      #1;
      for (int g = 0; g < 10; g++) begin
         int  n;
         bit  exp_fetch;
         n = 0;
         exp_fetch = (g == 4) || (g == 9);
         while (bus.mem_req_o !== 1'b1 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk($sformatf("starve_g%0d_wait", g), 32'(n < 8), 32'h1);
         if (n >= 8) break;
         chk($sformatf("starve_g%0d_owner", g), bus.mem_addr_o,
             exp_fetch ? 32'h400 : 32'h800);
         bus.mem_ack_i   = 1'b1;
         bus.mem_rdata_i = 32'h1000 + 32'(g);
         @(negedge clk);
         bus.mem_ack_i = 1'b0;
         #1;
         chk($sformatf("starve_g%0d_if_done", g), 32'(bus.if_done_o), 32'(exp_fetch));
         chk($sformatf("starve_g%0d_d_done", g),  32'(bus.d_done_o),  32'(!exp_fetch));
         $display("[TB] starvation grant %0d: expected %s, addr=0x%08h", g,
                  exp_fetch ? "fetch" : "data", bus.mem_addr_o);
      end
      @(negedge clk);
      drive_idle();

      // ---------------------------------------------------------------
      // Reset while BUSY: no done pulse, all outputs at reset values
      // ---------------------------------------------------------------
      @(negedge clk);
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h2004; bus.d_wdata_i = 32'h55AA;
      bus.d_ctrl_i = 3'b001; bus.d_we_i = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_busy_mem_req", 32'(bus.mem_req_o), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      drive_idle();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mem_req",   32'(bus.mem_req_o),  32'h0);
      chk("rst_mem_addr",  bus.mem_addr_o,      32'h0);
      chk("rst_mem_wdata", bus.mem_wdata_o,     32'h0);
      chk("rst_mem_ctrl",  32'(bus.mem_ctrl_o), 32'h0);
      chk("rst_mem_we",    32'(bus.mem_we_o),   32'h0);
      chk("rst_d_done",    32'(bus.d_done_o),   32'h0);
      chk("rst_if_done",   32'(bus.if_done_o),  32'h0);
      chk("rst_if_rdata",  bus.if_rdata_o,      32'h0);
      chk("rst_d_rdata",   bus.d_rdata_o,       32'h0);
      @(negedge clk);
      #1;
      chk("rst_next_d_done",  32'(bus.d_done_o),  32'h0);
      chk("rst_next_mem_req", 32'(bus.mem_req_o), 32'h0);
      $display("[TB] reset mid-BUSY: outputs cleared, no done pulse");
      // A fresh fetch is granted one cycle after being seen, so the FSM is in IDLE.
      @(negedge clk);
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h600;
      @(negedge clk);
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h600D600D;
      #1;
      chk("post_rst_mem_req", 32'(bus.mem_req_o), 32'h1);
      chk("post_rst_addr",    bus.mem_addr_o,     32'h600);
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      #1;
      chk("post_rst_if_done",  32'(bus.if_done_o), 32'h1);
      chk("post_rst_if_rdata", bus.if_rdata_o,     32'h600D600D);
      $display("[TB] post-reset fetch: if_rdata=0x%08h", bus.if_rdata_o);
      @(negedge clk);
      drive_idle();
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
